// File: rtl/tcdm_demux_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tcdm_demux_pkg
// Brief    : Shared types and the address decoder for the 1-to-2 TCDM demux.
// Revision : 1.0 - initial release
// ============================================================================
package tcdm_demux_pkg;

  // Which downstream source a request is routed to / a response comes from.
  typedef enum logic [1:0] {
    SEL_T0  = 2'd0,
    SEL_T1  = 2'd1,
    SEL_ERR = 2'd2
  } tgt_sel_e;

  // Decoder operands are widened to this width so one function serves any
  // ADDR_W up to 64 bits.
  localparam int unsigned DEC_W = 64;

  // Window match; target 0 wins when both windows contain the address.
  function automatic tgt_sel_e tcdm_decode(
    input logic [DEC_W-1:0] add,
    input logic [DEC_W-1:0] base0,
    input logic [DEC_W-1:0] mask0,
    input logic [DEC_W-1:0] base1,
    input logic [DEC_W-1:0] mask1
  );
    tgt_sel_e sel;
    if ((add & mask0) == base0) begin
      sel = SEL_T0;
    end else if ((add & mask1) == base1) begin
      sel = SEL_T1;
    end else begin
      sel = SEL_ERR;
    end
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tcdm_err_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tcdm_err_slave
// Brief    : Terminates unmapped TCDM accesses. Every accepted request gets a
//            response one cycle later carrying ERR_RDATA, plus an err pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tcdm_err_slave #(
  parameter int unsigned       DATA_W    = 32,
  parameter logic [DATA_W-1:0] ERR_RDATA = 32'hBADA_CCE5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  output logic              r_valid_o,
  output logic [DATA_W-1:0] r_rdata_o,
  output logic              err_o
);

  logic r_valid_d;
  logic r_valid_q;

  // A request is always accepted, so the response simply follows it by one cycle.
  always_comb begin
    r_valid_d = req_i;
  end

  // Response-valid register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid_q <= 1'b0;
    end else begin
      r_valid_q <= r_valid_d;
    end
  end

  assign r_valid_o = r_valid_q;
  assign r_rdata_o = r_valid_q ? ERR_RDATA : '0;
  assign err_o     = r_valid_q;

endmodule
`default_nettype wire

// File: rtl/tcdm_demux_1x2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tcdm_demux_1x2
// Brief    : Routes one TCDM initiator to two TCDM targets by address window,
//            returns responses in order and terminates unmapped accesses in
//            an internal error responder. err_o is a sticky error flag.
// Revision : 1.0 - initial release
// ============================================================================
module tcdm_demux_1x2 #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE0     = 32'h1C00_0000,
  parameter logic [ADDR_W-1:0] MASK0     = 32'hFFF0_0000,
  parameter logic [ADDR_W-1:0] BASE1     = 32'h1A10_0000,
  parameter logic [ADDR_W-1:0] MASK1     = 32'hFFFF_0000,
  parameter int unsigned       MAX_OUTST = 4,
  parameter logic [DATA_W-1:0] ERR_RDATA = 32'hBADA_CCE5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  // initiator side
  input  logic                slv_req_i,
  input  logic                slv_wen_i,
  input  logic [ADDR_W-1:0]   slv_add_i,
  input  logic [DATA_W-1:0]   slv_wdata_i,
  input  logic [DATA_W/8-1:0] slv_be_i,
  output logic                slv_gnt_o,
  output logic                slv_r_valid_o,
  output logic [DATA_W-1:0]   slv_r_rdata_o,
  // target 0
  output logic                mst0_req_o,
  output logic                mst0_wen_o,
  output logic [ADDR_W-1:0]   mst0_add_o,
  output logic [DATA_W-1:0]   mst0_wdata_o,
  output logic [DATA_W/8-1:0] mst0_be_o,
  input  logic                mst0_gnt_i,
  input  logic                mst0_r_valid_i,
  input  logic [DATA_W-1:0]   mst0_r_rdata_i,
  // target 1
  output logic                mst1_req_o,
  output logic                mst1_wen_o,
  output logic [ADDR_W-1:0]   mst1_add_o,
  output logic [DATA_W-1:0]   mst1_wdata_o,
  output logic [DATA_W/8-1:0] mst1_be_o,
  input  logic                mst1_gnt_i,
  input  logic                mst1_r_valid_i,
  input  logic [DATA_W-1:0]   mst1_r_rdata_i,
  // sticky error flag
  output logic                err_o
);

  import tcdm_demux_pkg::*;

  localparam int unsigned      CNT_W   = $clog2(MAX_OUTST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]  cnt_d;
  logic [CNT_W-1:0]  cnt_q;
  tgt_sel_e          last_sel_d;
  tgt_sel_e          last_sel_q;
  logic              err_d;
  logic              err_q;

  tgt_sel_e          sel;
  logic              issue_ok;
  logic              grant;
  logic              resp_src_valid;
  logic [DATA_W-1:0] resp_src_rdata;
  logic              resp_accept;
  logic              violation;

  logic              err_req;
  logic              err_r_valid;
  logic [DATA_W-1:0] err_r_rdata;
  logic              err_pulse;

  tcdm_err_slave #(
    .DATA_W    (DATA_W),
    .ERR_RDATA (ERR_RDATA)
  ) u_err_slave (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (err_req),
    .r_valid_o (err_r_valid),
    .r_rdata_o (err_r_rdata),
    .err_o     (err_pulse)
  );

  // Decode the initiator address into a target select.
  always_comb begin
    sel = tcdm_decode(DEC_W'(slv_add_i), DEC_W'(BASE0), DEC_W'(MASK0),
                      DEC_W'(BASE1), DEC_W'(MASK1));
  end

  // Pick the response source that owns the outstanding requests; anything
  // else raising r_valid (or anything at all while idle) is a violation.
  always_comb begin
    resp_src_valid = 1'b0;
    resp_src_rdata = '0;
    case (last_sel_q)
      SEL_T0: begin
        resp_src_valid = mst0_r_valid_i;
        resp_src_rdata = mst0_r_rdata_i;
      end
      SEL_T1: begin
        resp_src_valid = mst1_r_valid_i;
        resp_src_rdata = mst1_r_rdata_i;
      end
      default: begin
        resp_src_valid = err_r_valid;
        resp_src_rdata = err_r_rdata;
      end
    endcase
    resp_accept = resp_src_valid && (cnt_q != '0);
    violation   = (mst0_r_valid_i && !(resp_accept && (last_sel_q == SEL_T0))) ||
                  (mst1_r_valid_i && !(resp_accept && (last_sel_q == SEL_T1))) ||
                  (err_r_valid    && !(resp_accept && (last_sel_q == SEL_ERR)));
  end

  // Issue gating and grant. Requests may only follow outstanding ones to the
  // same target, unless this cycle's response retires the last one. Reset
  // blanks all handshakes immediately, independent of the clock.
  always_comb begin
    issue_ok = !rst_i && slv_req_i &&
               (((cnt_q < CNT_MAX) && ((cnt_q == '0) || (sel == last_sel_q))) ||
                (resp_accept && (cnt_q == CNT_ONE)));
    case (sel)
      SEL_T0:  grant = issue_ok && mst0_gnt_i;
      SEL_T1:  grant = issue_ok && mst1_gnt_i;
      default: grant = issue_ok;
    endcase
    err_req = issue_ok && (sel == SEL_ERR);
  end

  // Next-state for the outstanding counter, last target and sticky error.
  always_comb begin
    cnt_d = cnt_q;
    if (grant && !resp_accept) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (!grant && resp_accept) begin
      cnt_d = cnt_q - CNT_ONE;
    end
    last_sel_d = grant ? sel : last_sel_q;
    err_d      = err_q || violation || err_pulse;
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      last_sel_q <= SEL_T0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      last_sel_q <= last_sel_d;
      err_q      <= err_d;
    end
  end

  // Request fan-out: only the selected target sees req, data always mirrors.
  assign mst0_req_o    = issue_ok && (sel == SEL_T0);
  assign mst0_wen_o    = slv_wen_i;
  assign mst0_add_o    = slv_add_i;
  assign mst0_wdata_o  = slv_wdata_i;
  assign mst0_be_o     = slv_be_i;

  assign mst1_req_o    = issue_ok && (sel == SEL_T1);
  assign mst1_wen_o    = slv_wen_i;
  assign mst1_add_o    = slv_add_i;
  assign mst1_wdata_o  = slv_wdata_i;
  assign mst1_be_o     = slv_be_i;

  // Initiator side.
  assign slv_gnt_o     = grant;
  assign slv_r_valid_o = resp_accept;
  assign slv_r_rdata_o = resp_accept ? resp_src_rdata : '0;
  assign err_o         = err_q;

endmodule
`default_nettype wire
